alu_responder: RTL and testbench

Responder end of the execute-stage dat_ready/ALU_ready handshake. It accepts an operation when dat_ready rises and returns a registered 32-bit result plus overflow, zero, condition-met and error flags with ALU_ready. It sits under the EX-stage controller, inside the EX reset domain. Single-cycle response latency, so a result is available in stage 3 of the controller's 4-stage counter.

---
 rtl/alu_resp_pkg.sv | 35 +++
 rtl/alu_resp_core.sv | 79 +++++++
 rtl/alu_responder.sv | 94 +++++++++
 tb/tb_alu_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_resp_pkg.sv
// Shared types and widths for the execute-stage ALU responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional reserved-opcode checking is selected by ALU_RESP_OPCHK_EN.
package alu_resp_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_BLT   = 5'd12,
        OP_BGE   = 5'd13,
        OP_BLTU  = 5'd14,
        OP_BGEU  = 5'd15,
        OP_PASSB = 5'd16
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_e;

endpackage

// File: rtl/alu_resp_core.sv
// Combinational ALU datapath: operands and opcode in, result and four flags out.
// Latency: zero cycles (pure combinational logic).
// Backpressure: none; the caller decides when to register the outputs.
// ALU_RESP_OPCHK_EN defined: opcodes 17-31 raise err with a zero result and clear flags.
// ALU_RESP_OPCHK_EN undefined: opcodes 17-31 behave exactly like ADD and err stays 0.
module alu_resp_core
    import alu_resp_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] res_o,
    output logic              ovf_o,
    output logic              con_met_o,
    output logic              zero_o,
    output logic              err_o
);

    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic signed [DATA_W-1:0] a_s;
    logic [SHAMT_W-1:0]       shamt;
    logic                     lt_s;
    logic                     lt_u;
    logic                     eq;
    logic                     add_ovf;
    logic                     sub_ovf;

    assign sum   = a_i + b_i;
    assign diff  = a_i - b_i;
    assign a_s   = a_i;
    assign shamt = b_i[SHAMT_W-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;
    assign eq    = a_i == b_i;

    // Overflow only exists for two's-complement add/subtract.
    assign add_ovf = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1]  != a_i[DATA_W-1]);
    assign sub_ovf = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);

    // Opcode decode; branches return A-B so the controller can reuse the difference.
    always_comb begin
        res_o     = '0;
        ovf_o     = 1'b0;
        con_met_o = 1'b0;
        err_o     = 1'b0;
        case (op_i)
            OP_ADD:   begin res_o = sum;  ovf_o = add_ovf; end
            OP_SUB:   begin res_o = diff; ovf_o = sub_ovf; end
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_SLL:   res_o = a_i << shamt;
            OP_SRL:   res_o = a_i >> shamt;
            OP_SRA:   res_o = a_s >>> shamt;
            OP_SLT:   begin res_o = {{(DATA_W-1){1'b0}}, lt_s}; con_met_o = lt_s; end
            OP_SLTU:  begin res_o = {{(DATA_W-1){1'b0}}, lt_u}; con_met_o = lt_u; end
            OP_BEQ:   begin res_o = diff; con_met_o = eq;    end
            OP_BNE:   begin res_o = diff; con_met_o = !eq;   end
            OP_BLT:   begin res_o = diff; con_met_o = lt_s;  end
            OP_BGE:   begin res_o = diff; con_met_o = !lt_s; end
            OP_BLTU:  begin res_o = diff; con_met_o = lt_u;  end
            OP_BGEU:  begin res_o = diff; con_met_o = !lt_u; end
            OP_PASSB: res_o = b_i;
            default: begin
`ifdef ALU_RESP_OPCHK_EN
                err_o = 1'b1;
`else
                res_o = sum;
                ovf_o = add_ovf;
`endif
            end
        endcase
    end

    // Zero reflects the final result; an error response reports no flags at all.
    assign zero_o = (res_o == '0) && !err_o;

endmodule

// File: rtl/alu_responder.sv
// Responder side of the EX-stage dat_ready/ALU_ready handshake around a combinational ALU.
// Latency: one cycle; results and ALU_ready register on the edge that samples dat_ready rising.
// Backpressure: one capture per dat_ready high phase; ALU_ready holds until dat_ready is sampled low.
// Optional reserved-opcode error reporting is enabled by defining ALU_RESP_OPCHK_EN.
module alu_responder
    import alu_resp_pkg::*;
(
    input  logic              soc_clk,
    input  logic              EX_reset,
    input  logic              dat_ready,
    input  logic [DATA_W-1:0] ALU_dat1,
    input  logic [DATA_W-1:0] ALU_dat2,
    input  logic [OP_W-1:0]   Instruction_to_ALU,
    output logic [DATA_W-1:0] ALU_out,
    output logic              ALU_overflow,
    output logic              ALU_con_met,
    output logic              ALU_zero,
    output logic              ALU_err,
    output logic              ALU_ready
);

    resp_state_e       state_q;
    logic              dat_ready_q;
    logic [DATA_W-1:0] out_q;
    logic              ovf_q;
    logic              con_met_q;
    logic              zero_q;
    logic              err_q;
    logic              ready_q;

    logic [DATA_W-1:0] out_d;
    logic              ovf_d;
    logic              con_met_d;
    logic              zero_d;
    logic              err_d;

    alu_resp_core u_core (
        .a_i       (ALU_dat1),
        .b_i       (ALU_dat2),
        .op_i      (Instruction_to_ALU),
        .res_o     (out_d),
        .ovf_o     (ovf_d),
        .con_met_o (con_met_d),
        .zero_o    (zero_d),
        .err_o     (err_d)
    );

    // Edge detect, handshake FSM and result registers; results persist until the next capture.
    always_ff @(posedge soc_clk or posedge EX_reset) begin
        if (EX_reset) begin
            state_q     <= ST_IDLE;
            dat_ready_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            con_met_q   <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            dat_ready_q <= dat_ready;
            case (state_q)
                ST_IDLE: begin
                    if (dat_ready && !dat_ready_q) begin
                        out_q     <= out_d;
                        ovf_q     <= ovf_d;
                        con_met_q <= con_met_d;
                        zero_q    <= zero_d;
                        err_q     <= err_d;
                        ready_q   <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!dat_ready) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ALU_out      = out_q;
    assign ALU_overflow = ovf_q;
    assign ALU_con_met  = con_met_q;
    assign ALU_zero     = zero_q;
    assign ALU_err      = err_q;
    assign ALU_ready    = ready_q;

endmodule

// File: tb/tb_alu_responder.sv
// Scoreboard bench for alu_responder: expectations queued at request, checked on each ALU_ready rise.
// Latency: checks the one-cycle response and the one-edge drop after dat_ready is sampled low.
// Backpressure: exercises long dat_ready high phases, reset mid-response and reset release with request high.
module tb_alu_responder;

    logic        soc_clk;
    logic        EX_reset;
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] ALU_out;
    logic        ALU_overflow;
    logic        ALU_con_met;
    logic        ALU_zero;
    logic        ALU_err;
    logic        ALU_ready;

    typedef struct {
        logic [31:0] out;
        logic        ov;
        logic        cm;
        logic        z;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_responder dut (
        .soc_clk            (soc_clk),
        .EX_reset           (EX_reset),
        .dat_ready          (dat_ready),
        .ALU_dat1           (ALU_dat1),
        .ALU_dat2           (ALU_dat2),
        .Instruction_to_ALU (Instruction_to_ALU),
        .ALU_out            (ALU_out),
        .ALU_overflow       (ALU_overflow),
        .ALU_con_met        (ALU_con_met),
        .ALU_zero           (ALU_zero),
        .ALU_err            (ALU_err),
        .ALU_ready          (ALU_ready)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] out, input logic ov, input logic cm,
                                input logic z, input logic err);
        exp_t e;
        e.out = out; e.ov = ov; e.cm = cm; e.z = z; e.err = err;
        return e;
    endfunction

    // Reference model: 33-bit sign-extended arithmetic for overflow, MSB-flip for signed compare.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        logic [32:0] d;
        logic [63:0] ext;
        logic        slt;
        logic        ult;
        int          sh;
        s   = {a[31], a} + {b[31], b};
        d   = {a[31], a} - {b[31], b};
        sh  = int'(b & 32'h1f);
        ext = {{32{a[31]}}, a} >> sh;
        slt = {~a[31], a[30:0]} < {~b[31], b[30:0]};
        ult = a < b;
        e = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (op)
            5'd0:  begin e.out = s[31:0]; e.ov = s[32] ^ s[31]; end
            5'd1:  begin e.out = d[31:0]; e.ov = d[32] ^ d[31]; end
            5'd2:  e.out = a & b;
            5'd3:  e.out = a | b;
            5'd4:  e.out = a ^ b;
            5'd5:  e.out = a << sh;
            5'd6:  e.out = a >> sh;
            5'd7:  e.out = ext[31:0];
            5'd8:  begin e.out = {31'b0, slt}; e.cm = slt; end
            5'd9:  begin e.out = {31'b0, ult}; e.cm = ult; end
            5'd10: begin e.out = d[31:0]; e.cm = (a == b); end
            5'd11: begin e.out = d[31:0]; e.cm = (a != b); end
            5'd12: begin e.out = d[31:0]; e.cm = slt;  end
            5'd13: begin e.out = d[31:0]; e.cm = !slt; end
            5'd14: begin e.out = d[31:0]; e.cm = ult;  end
            5'd15: begin e.out = d[31:0]; e.cm = !ult; end
            5'd16: e.out = b;
            default: begin
`ifdef ALU_RESP_OPCHK_EN
                e.err = 1'b1;
`else
                e.out = s[31:0];
                e.ov  = s[32] ^ s[31];
`endif
            end
        endcase
        e.z = (e.out == 32'h0) && !e.err;
        return e;
    endfunction

    // Monitor: every ALU_ready rise consumes exactly one scoreboard entry.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge soc_clk);
            if (ALU_ready && !prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("out",      ALU_out,      e.out);
                    chk("overflow", 32'(ALU_overflow), 32'(e.ov));
                    chk("con_met",  32'(ALU_con_met),  32'(e.cm));
                    chk("zero",     32'(ALU_zero),     32'(e.z));
                    chk("err",      32'(ALU_err),      32'(e.err));
                end
            end
            prev = ALU_ready;
        end
    end

    // One full handshake: raise request, expect response next edge, hold, drop, expect release.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int hold);
        @(negedge soc_clk);
        Instruction_to_ALU = op;
        ALU_dat1  = a;
        ALU_dat2  = b;
        dat_ready = 1'b1;
        sb.push_back(e);
        @(negedge soc_clk);
        chk("lat_ready", 32'(ALU_ready), 32'd1);
        for (int i = 1; i < hold; i++) begin
            ALU_dat1 = ~a;
            ALU_dat2 = b + 32'd7;
            @(negedge soc_clk);
            chk("hold_ready", 32'(ALU_ready), 32'd1);
            chk("hold_out",   ALU_out, e.out);
        end
        dat_ready = 1'b0;
        @(negedge soc_clk);
        chk("drop_ready", 32'(ALU_ready), 32'd0);
        chk("keep_out",   ALU_out, e.out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        EX_reset  = 1'b1;
        dat_ready = 1'b0;
        ALU_dat1  = '0;
        ALU_dat2  = '0;
        Instruction_to_ALU = '0;
        repeat (2) @(negedge soc_clk);
        chk("rst_out",   ALU_out, 32'h0);
        chk("rst_ready", 32'(ALU_ready), 32'd0);
        chk("rst_flags", 32'({ALU_overflow, ALU_con_met, ALU_zero, ALU_err}), 32'd0);
        EX_reset = 1'b0;
        @(negedge soc_clk);
        chk("idle_ready", 32'(ALU_ready), 32'd0);

        issue(5'd0,  32'h7FFFFFFF, 32'h1, mk(32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0), 1);
        issue(5'd1,  32'h5,        32'h5, mk(32'h0,        1'b0, 1'b0, 1'b1, 1'b0), 1);
        issue(5'd12, 32'hFFFFFFFF, 32'h1, mk(32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0), 1);
        issue(5'd14, 32'hFFFFFFFF, 32'h1, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0), 1);
        issue(5'd7,  32'h80000000, 32'h21, mk(32'hC0000000, 1'b0, 1'b0, 1'b0, 1'b0), 1);
        issue(5'd1,  32'h80000000, 32'h1, mk(32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0), 1);
        issue(5'd8,  32'hFFFFFFFE, 32'h3, mk(32'h1,        1'b0, 1'b1, 1'b0, 1'b0), 1);
        issue(5'd16, 32'h1234,     32'hA5A5A5A5, mk(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0), 1);
        // long request: one capture only, later operand changes must not leak through
        issue(5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, mk(32'hFF00FF00, 1'b0, 1'b0, 1'b0, 1'b0), 5);
`ifdef ALU_RESP_OPCHK_EN
        issue(5'd20, 32'h2, 32'h3, mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1), 1);
`else
        issue(5'd20, 32'h2, 32'h3, mk(32'h5, 1'b0, 1'b0, 1'b0, 1'b0), 1);
`endif

        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = $urandom;
            rb  = (n % 4 == 0) ? ra : $urandom;
            issue(rop, ra, rb, model(rop, ra, rb), 1 + (n % 3));
        end

        // reset while responding clears outputs at once
        issue(5'd0, 32'h1, 32'h1, mk(32'h2, 1'b0, 1'b0, 1'b0, 1'b0), 2);
        @(negedge soc_clk);
        Instruction_to_ALU = 5'd2;
        ALU_dat1  = 32'hFFFF0000;
        ALU_dat2  = 32'h0FF00000;
        dat_ready = 1'b1;
        sb.push_back(mk(32'h0FF00000, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge soc_clk);
        chk("pre_rst_ready", 32'(ALU_ready), 32'd1);
        #2;
        EX_reset = 1'b1;
        #1;
        chk("async_rst_ready", 32'(ALU_ready), 32'd0);
        chk("async_rst_out",   ALU_out, 32'h0);
        chk("async_rst_flags", 32'({ALU_overflow, ALU_con_met, ALU_zero, ALU_err}), 32'd0);
        // request still high across reset release counts as a new rising edge
        Instruction_to_ALU = 5'd0;
        ALU_dat1 = 32'h2;
        ALU_dat2 = 32'h3;
        sb.push_back(mk(32'h5, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge soc_clk);
        EX_reset = 1'b0;
        @(negedge soc_clk);
        chk("rel_ready", 32'(ALU_ready), 32'd1);
        dat_ready = 1'b0;
        @(negedge soc_clk);
        chk("rel_drop", 32'(ALU_ready), 32'd0);
        repeat (2) @(negedge soc_clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
